div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_unit : 32-bit iterative restoring divider (DIV/DIVU), one bit per cycle |
// | Optional flush abort enabled by defining DIV_FLUSH_EN.                      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIV_ZERO = 2'd1;
  localparam logic [1:0] DIV_ON   = 2'd2;
  localparam logic [1:0] DIV_END  = 2'd3;

  localparam logic [5:0] LAST_STEP = 6'd31;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;

  logic [32:0] step_shift;
  logic [32:0] step_diff;
  logic        step_ge;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;

  // Partial remainder is always below the divisor, so the shifted value fits 33 bits
  // and bit 32 of the difference is a clean borrow flag.
  always_comb begin
    step_shift = {rem_q, quo_q[31]};
    step_diff  = step_shift - {1'b0, dvs_q};
    step_ge    = ~step_diff[32];
    step_rem   = step_ge ? step_diff[31:0] : step_shift[31:0];
    step_quo   = {quo_q[30:0], step_ge};
  end

  always_comb begin
    abs_dividend = (signed_div && dividend[31]) ? (32'd0 - dividend) : dividend;
    abs_divisor  = (signed_div && divisor[31])  ? (32'd0 - divisor)  : divisor;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          busy_d = 1'b1;
          cnt_d  = 6'd0;
          if (divisor == 32'd0) begin
            state_d = DIV_ZERO;
            quo_d   = dividend;
          end else begin
            state_d = DIV_ON;
            rem_d   = 32'd0;
            quo_d   = abs_dividend;
            dvs_d   = abs_divisor;
            qneg_d  = signed_div & (dividend[31] ^ divisor[31]);
            rneg_d  = signed_div & dividend[31];
          end
        end
      end

      DIV_ZERO: begin
        state_d     = DIV_END;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        quotient_d  = 32'hFFFF_FFFF;
        remainder_d = quo_q;
      end

      DIV_ON: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d     = DIV_END;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_d       = 6'd0;
          quotient_d  = qneg_q ? (32'd0 - step_quo) : step_quo;
          remainder_d = rneg_q ? (32'd0 - step_rem) : step_rem;
        end
      end

      DIV_END: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef DIV_FLUSH_EN
    if (flush && (state_q == DIV_ZERO || state_q == DIV_ON)) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cnt_d       = 6'd0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// Testbench for div_unit: directed and randomized divides against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;
  logic [31:0] hold_q = 32'd0;
  logic [31:0] hold_r = 32'd0;

`ifdef DIV_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; signed_div = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
    rst = 1'b0;
    hold_q = 32'd0;
    hold_r = 32'd0;
  endtask

  // Start a divide in cycle 0 and check busy/done/outputs every cycle until it settles.
  // flush_at / junk_at (0 = none) inject a flush or an ignored start in that cycle.
  task automatic run_div(input string name, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input int flush_at, input int junk_at);
    logic [31:0] eq, er, xq, xr;
    int   exp_done, last;
    bit   flushed, xbusy, xdone;
    ref_div(sd, a, b, eq, er);
    exp_done = (b == 32'd0) ? 2 : 33;
    flushed  = FLUSH_EN && flush_at >= 1 && flush_at < exp_done;
    last     = flushed ? flush_at + 1 : exp_done;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sd; dividend = a; divisor = b; flush = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == junk_at);
      flush = (cyc == flush_at);
      if (cyc == junk_at) begin
        signed_div = $urandom_range(0, 1);
        dividend   = $urandom;
        divisor    = $urandom;
      end
      xbusy = (cyc < exp_done) && (!flushed || cyc <= flush_at);
      xdone = !flushed && (cyc == exp_done);
      if (xdone) begin
        hold_q = eq;
        hold_r = er;
      end
      xq = hold_q;
      xr = hold_r;
      checks++; if (busy !== xbusy) begin errors++; $display("FAIL %s busy cyc %0d got %b want %b", name, cyc, busy, xbusy); end
      checks++; if (done !== xdone) begin errors++; $display("FAIL %s done cyc %0d got %b want %b", name, cyc, done, xdone); end
      checks++; if (quotient !== xq) begin errors++; $display("FAIL %s quotient cyc %0d got %h want %h", name, cyc, quotient, xq); end
      checks++; if (remainder !== xr) begin errors++; $display("FAIL %s remainder cyc %0d got %h want %h", name, cyc, remainder, xr); end
      checks++; if (busy === 1'b1 && done === 1'b1) begin errors++; $display("FAIL %s busy_and_done cyc %0d got 1 want 0", name, cyc); end
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_directed();
    run_div("u100_7",     1'b0, 32'd100,       32'd7,         0, 0);
    run_div("s_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         0, 0);
    run_div("s_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 0, 0);
    run_div("div0",       1'b0, 32'h1234_5678, 32'd0,         0, 0);
    run_div("s_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div("u_max_1",    1'b0, 32'hFFFF_FFFF, 32'd1,         0, 0);
    run_div("s_div0",     1'b1, 32'h8765_4321, 32'd0,         0, 0);
  endtask

  task automatic test_start_ignored();
    run_div("ign_mid",    1'b0, 32'd1000,      32'd33,        0, 5);
    run_div("ign_zero",   1'b1, 32'hDEAD_BEEF, 32'd0,         0, 1);
  endtask

  task automatic test_flush();
    run_div("flush10",    1'b0, 32'd123456,    32'd789,       10, 0);
    run_div("flush_dz",   1'b0, 32'hCAFE_F00D, 32'd0,         1, 0);
  endtask

  task automatic test_start_flush_idle();
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; signed_div = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush busy cyc %0d got %b want 0", cyc, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_flush done cyc %0d got %b want 0", cyc, done); end
      checks++; if (quotient !== hold_q) begin errors++; $display("FAIL idle_flush quotient got %h want %h", quotient, hold_q); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    bit xbusy, xdone;
    logic [31:0] xq, xr;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; dividend = 32'h0001_2345; divisor = 32'd3;
    for (int cyc = 1; cyc <= 56; cyc++) begin
      @(posedge clk); #1;
      rst   = (cyc == 15);
      start = (cyc == 20);
      if (cyc == 20) begin
        signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
      end
      if (cyc == 16) begin hold_q = 32'd0; hold_r = 32'd0; end
      if (cyc == 53) begin hold_q = 32'd10; hold_r = 32'd0; end
      xbusy = (cyc <= 15) || (cyc >= 21 && cyc <= 52);
      xdone = (cyc == 53);
      xq = hold_q;
      xr = hold_r;
      checks++; if (busy !== xbusy) begin errors++; $display("FAIL rst_mid busy cyc %0d got %b want %b", cyc, busy, xbusy); end
      checks++; if (done !== xdone) begin errors++; $display("FAIL rst_mid done cyc %0d got %b want %b", cyc, done, xdone); end
      checks++; if (quotient !== xq) begin errors++; $display("FAIL rst_mid quotient cyc %0d got %h want %h", cyc, quotient, xq); end
      checks++; if (remainder !== xr) begin errors++; $display("FAIL rst_mid remainder cyc %0d got %h want %h", cyc, remainder, xr); end
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_random();
    logic        sd;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sd = $urandom_range(0, 1);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'd0};
      run_div("rand", sd, a, b, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    run_div("b2b_0", 1'b1, 32'hFFFF_FF00, 32'd16,        0, 0);
    run_div("b2b_1", 1'b0, 32'd0,         32'd5,         0, 0);
    run_div("b2b_2", 1'b1, 32'd5,         32'hFFFF_FFF6, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_flush();
    test_start_flush_idle();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
